// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared phase type, control-word layout and constants for control_sequencer
//
// Purpose: types and constants shared by control_sequencer and its sub-module.
// Contents:
//   phase_t        - sequencer phase (FETCH, EXECUTE, HALT, FAULT, STEP_WAIT)
//   CW_*           - bit indices into the 33-bit control word
//   PC_FS_*        - program-counter function-select encodings
//   FETCH_WORD     - control word driven while fetching (PC hold, RAM read)
//   UDF_ENCODING   - instruction word that halts the sequencer
package control_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    EXECUTE   = 3'd1,
    HALT      = 3'd2,
    FAULT     = 3'd3,
    STEP_WAIT = 3'd4
  } phase_t;

  localparam int CW_WIDTH     = 33;
  localparam int CW_ALU_EN    = 32;
  localparam int CW_ALU_B_SEL = 31;
  localparam int CW_ALU_FS_LSB = 26;
  localparam int CW_RF_B_EN   = 25;
  localparam int CW_SA_LSB    = 20;
  localparam int CW_SB_LSB    = 15;
  localparam int CW_DA_LSB    = 10;
  localparam int CW_RF_WR     = 9;
  localparam int CW_RAM_EN    = 8;
  localparam int CW_RAM_WR    = 7;
  localparam int CW_PC_EN     = 6;
  localparam int CW_PC_FS_MSB = 5;
  localparam int CW_PC_FS_LSB = 4;
  localparam int CW_PC_SEL    = 3;
  localparam int CW_STATUS_LD = 2;
  localparam int CW_NS_MSB    = 1;
  localparam int CW_NS_LSB    = 0;

  localparam logic [1:0] PC_FS_HOLD   = 2'b00;
  localparam logic [1:0] PC_FS_INC    = 2'b01;
  localparam logic [1:0] PC_FS_BRANCH = 2'b11;

  // PC enabled with hold function and RAM enabled for read; everything else off.
  localparam logic [CW_WIDTH-1:0] FETCH_WORD =
      (33'd1 << CW_PC_EN) | (33'd1 << CW_RAM_EN) |
      ({31'd0, PC_FS_HOLD} << CW_PC_FS_LSB);

  localparam logic [31:0] UDF_ENCODING = 32'h0000_0000;

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - cycle counter bounding how long a fetch may wait for memory
//
// Purpose: counts fetch cycles spent without mem_ready and flags the cycle on
// which the count reaches LIMIT.
// Ports:
//   clock   in  1      system clock, rising edge
//   reset   in  1      asynchronous, active-low
//   clear   in  1      return count to zero (has priority over enable)
//   enable  in  1      count this cycle
//   expired out 1      this enabled cycle brings the count to LIMIT
module fetch_timeout_counter #(
  parameter int LIMIT = 15,
  parameter int WIDTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Flag the cycle whose increment would take the count to LIMIT, so the
  // LIMIT-th waiting cycle is the last one tolerated.
  assign expired = enable && (r_count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute sequencer feeding opcode decoders and the datapath
//
// Purpose: fetches instructions over a request/ready handshake, holds the
// instruction register, micro-state and status flags for the decoders, and
// forwards the selected decoder's control word to the datapath.
// Optional feature: CONTROL_SEQUENCER_SINGLE_STEP_EN adds a step input and a
// STEP_WAIT phase between instructions (and after reset).
// Ports:
//   clock               in  1   system clock, rising edge
//   reset               in  1   asynchronous, active-low
//   step                in  1   (single-step build only) release STEP_WAIT
//   instr_in            in  32  RAM data bus
//   mem_ready           in  1   RAM has valid instr_in this cycle
//   decoder_controlword in  33  control word from the selected decoder
//   status_in           in  5   ALU flags
//   instruction         out 32  instruction register
//   state               out 2   micro-state
//   status              out 5   registered flags
//   controlword         out 33  word driven to the datapath
//   mem_request         out 1   fetch request to RAM
//   halted              out 1   HALT reached
//   fault               out 1   fetch timeout
module control_sequencer
  import control_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 15,
  parameter int TIMEOUT_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [31:0]         instr_in,
  input  logic                mem_ready,
  input  logic [CW_WIDTH-1:0] decoder_controlword,
  input  logic [4:0]          status_in,
  output logic [31:0]         instruction,
  output logic [1:0]          state,
  output logic [4:0]          status,
  output logic [CW_WIDTH-1:0] controlword,
  output logic                mem_request,
  output logic                halted,
  output logic                fault
);

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  localparam phase_t IDLE_PHASE = STEP_WAIT;
`else
  localparam phase_t IDLE_PHASE = FETCH;
`endif

  phase_t      r_phase;
  logic [31:0] r_instruction;
  logic [1:0]  r_state;
  logic [4:0]  r_status;

  logic        w_in_fetch;
  logic        w_expired;
  logic [1:0]  w_next_state;

  assign w_in_fetch   = (r_phase == FETCH);
  assign w_next_state = decoder_controlword[CW_NS_MSB:CW_NS_LSB];

  // Counter only runs while a fetch is waiting; any other phase or a completed
  // handshake returns it to zero.
  fetch_timeout_counter #(
    .LIMIT (FETCH_TIMEOUT),
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (!w_in_fetch || mem_ready),
    .enable  (w_in_fetch && !mem_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase       <= IDLE_PHASE;
      r_instruction <= '0;
      r_state       <= 2'b00;
      r_status      <= '0;
    end else begin
      case (r_phase)
        FETCH: begin
          // A ready on the timeout cycle still completes the fetch.
          if (mem_ready) begin
            r_instruction <= instr_in;
            r_state       <= 2'b00;
            r_phase       <= (instr_in == UDF_ENCODING) ? HALT : EXECUTE;
          end else if (w_expired) begin
            r_phase <= FAULT;
          end
        end
        EXECUTE: begin
          if (decoder_controlword[CW_STATUS_LD]) begin
            r_status <= status_in;
          end
          if (w_next_state == 2'b00) begin
            r_state <= 2'b00;
            r_phase <= IDLE_PHASE;
          end else begin
            r_state <= w_next_state;
          end
        end
        HALT:  r_phase <= HALT;
        FAULT: r_phase <= FAULT;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
        STEP_WAIT: begin
          if (step) begin
            r_phase <= FETCH;
          end
        end
`endif
        default: r_phase <= IDLE_PHASE;
      endcase
    end
  end

  // Outputs decode the registered phase; the control word also passes the
  // decoder word through in EXECUTE and signals PC+4 on the ready cycle.
  always_comb begin
    controlword = '0;
    case (r_phase)
      FETCH: begin
        controlword = FETCH_WORD;
        if (mem_ready) begin
          controlword[CW_PC_FS_MSB:CW_PC_FS_LSB] = PC_FS_INC;
        end
      end
      EXECUTE: controlword = decoder_controlword;
      default: controlword = '0;
    endcase
  end

  assign mem_request = w_in_fetch;
  assign halted      = (r_phase == HALT);
  assign fault       = (r_phase == FAULT);
  assign instruction = r_instruction;
  assign state       = r_state;
  assign status      = r_status;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] instr_in;
  logic        mem_ready;
  logic [32:0] decoder_controlword;
  logic [4:0]  status_in;
  logic [31:0] instruction;
  logic [1:0]  state;
  logic [4:0]  status;
  logic [32:0] controlword;
  logic        mem_request;
  logic        halted;
  logic        fault;

  int n_asserts = 0;
  int n_fails   = 0;

  localparam logic [32:0] FETCH_CW = 33'h0_0000_0140;
  localparam logic [32:0] READY_CW = 33'h0_0000_0150;
  localparam logic [32:0] DCW1     = 33'h1_5A5A_0001;
  localparam logic [32:0] DCW2     = 33'h0_A5A5_0002;
  localparam logic [32:0] DCW3     = 33'h1_0000_0F00;

  control_sequencer dut (
    .clock               (clock),
    .reset               (reset),
    .instr_in            (instr_in),
    .mem_ready           (mem_ready),
    .decoder_controlword (decoder_controlword),
    .status_in           (status_in),
    .instruction         (instruction),
    .state               (state),
    .status              (status),
    .controlword         (controlword),
    .mem_request         (mem_request),
    .halted              (halted),
    .fault               (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    mem_ready = 1'b0;
    instr_in = 32'h0;
    decoder_controlword = 33'h0;
    status_in = 5'h0;

    repeat (2) @(negedge clock);
    #1;
    check("rst_instruction", instruction, 0);
    check("rst_state", state, 0);
    check("rst_status", status, 0);
    check("rst_cw", controlword, FETCH_CW);
    check("rst_req", mem_request, 1);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    reset = 1'b1;

    // Fetch with ready on the third request cycle.
    check("f1_req_c1", mem_request, 1);
    @(negedge clock); #1;
    check("f1_req_c2", mem_request, 1);
    check("f1_cw_c2", controlword, FETCH_CW);
    @(negedge clock);
    mem_ready = 1'b1; instr_in = 32'hB400_0041;
    #1;
    check("f1_req_c3", mem_request, 1);
    check("f1_cw_ready", controlword, READY_CW);
    @(negedge clock);
    mem_ready = 1'b0; instr_in = 32'hFFFF_FFFF; decoder_controlword = DCW1;
    #1;
    check("f1_instruction", instruction, 32'hB400_0041);
    check("f1_state", state, 0);
    check("f1_req_off", mem_request, 0);
    check("ex_cw_pass1", controlword, DCW1);

    // Micro-state sequence 01, 10, 00.
    @(negedge clock);
    decoder_controlword = DCW2;
    #1;
    check("ex_state_01", state, 2'b01);
    check("ex_cw_pass2", controlword, DCW2);
    @(negedge clock);
    decoder_controlword = DCW3;
    #1;
    check("ex_state_10", state, 2'b10);
    @(negedge clock); #1;
    check("ex_back_req", mem_request, 1);
    check("ex_back_state", state, 0);
    check("ex_back_cw", controlword, FETCH_CW);

    // Status load on, then off.
    mem_ready = 1'b1; instr_in = 32'h1234_5678;
    @(negedge clock);
    mem_ready = 1'b0; decoder_controlword = 33'h0_0000_0005; status_in = 5'b10101;
    #1;
    check("st_instruction", instruction, 32'h1234_5678);
    @(negedge clock);
    decoder_controlword = 33'h1_0000_0010; status_in = 5'b01010;
    #1;
    check("st_loaded", status, 5'b10101);
    @(negedge clock); #1;
    check("st_unchanged", status, 5'b10101);
    check("st_req", mem_request, 1);

    // Fetch timeout: mem_ready low for 15 cycles.
    for (int i = 0; i < 15; i++) begin
      check("to_req", mem_request, 1);
      check("to_nofault", fault, 0);
      @(negedge clock); #1;
    end
    check("to_fault", fault, 1);
    check("to_cw", controlword, 0);
    check("to_req_off", mem_request, 0);
    mem_ready = 1'b1; decoder_controlword = DCW1;
    repeat (3) @(negedge clock);
    #1;
    check("to_fault_held", fault, 1);
    check("to_cw_held", controlword, 0);
    check("to_req_held", mem_request, 0);

    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    check("to_rst_fault", fault, 0);
    check("to_rst_req", mem_request, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;

    // Ready on the 15th waiting cycle.
    for (int i = 0; i < 14; i++) begin
      check("r15_req", mem_request, 1);
      @(negedge clock); #1;
    end
    mem_ready = 1'b1; instr_in = 32'h0000_00A1;
    #1;
    check("r15_cw", controlword, READY_CW);
    check("r15_nofault", fault, 0);
    @(negedge clock);
    mem_ready = 1'b0; decoder_controlword = DCW3;
    #1;
    check("r15_nofault_after", fault, 0);
    check("r15_instruction", instruction, 32'h0000_00A1);
    check("r15_cw_pass", controlword, DCW3);
    @(negedge clock); #1;
    check("r15_back_req", mem_request, 1);

    // UDF fetch halts.
    mem_ready = 1'b1; instr_in = 32'h0;
    @(negedge clock);
    mem_ready = 1'b0; decoder_controlword = DCW1;
    #1;
    check("udf_halted", halted, 1);
    check("udf_cw", controlword, 0);
    check("udf_req", mem_request, 0);
    check("udf_instruction", instruction, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      @(negedge clock); #1;
      check("udf_req_held", mem_request, 0);
    end
    check("udf_halted_held", halted, 1);

    // Reset pulsed mid-execute at state 10.
    @(negedge clock);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    check("mx_rst_halted", halted, 0);
    @(negedge clock);
    reset = 1'b1; mem_ready = 1'b1; instr_in = 32'hC0DE_0001;
    @(negedge clock);
    mem_ready = 1'b0; decoder_controlword = 33'h0_0000_0005; status_in = 5'b11011;
    #1;
    check("mx_state_00", state, 0);
    @(negedge clock);
    decoder_controlword = DCW2;
    #1;
    check("mx_state_01", state, 2'b01);
    check("mx_status", status, 5'b11011);
    @(negedge clock);
    decoder_controlword = 33'h1_FFFF_FFF2;
    #1;
    check("mx_state_10", state, 2'b10);
    #2;
    reset = 1'b0;
    #1;
    check("mx_rst_instruction", instruction, 0);
    check("mx_rst_state", state, 0);
    check("mx_rst_status", status, 0);
    check("mx_rst_req", mem_request, 1);
    check("mx_rst_cw", controlword, FETCH_CW);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mx_restart_req", mem_request, 1);
    mem_ready = 1'b1; instr_in = 32'h0BAD_F00D;
    @(negedge clock);
    mem_ready = 1'b0;
    #1;
    check("mx_restart_instruction", instruction, 32'h0BAD_F00D);
    check("mx_restart_req_off", mem_request, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Sits directly upstream of the per-opcode decoders (CBZ/CBNZ, ALU, load/store, branch).
- Fetches each instruction from RAM over a request/ready handshake and holds it in the instruction register.
- Presents the instruction, the 2-bit micro-state and the registered status flags to the decoders.
- Issues the selected decoder's 33-bit control word to the datapath, advances the micro-state from that word's next_state field, and returns to fetch when next_state is 00.

Parameters:
- FETCH_TIMEOUT, 15: max cycles mem_request may wait for mem_ready before entering FAULT.
- TIMEOUT_WIDTH, 4: width of the timeout counter; must hold FETCH_TIMEOUT.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low.
- instr_in  input  32  RAM data bus carrying the fetched word.
- mem_ready  input  1  RAM has valid instr_in this cycle.
- decoder_controlword  input  33  control word from the opcode-selected decoder.
- status_in  input  5  ALU flags.
- instruction  output  32  instruction register, to decoders.
- state  output  2  micro-state, to decoders.
- status  output  5  registered flags, to decoders.
- controlword  output  33  word driven to the datapath.
- mem_request  output  1  fetch request to RAM.
- halted  output  1  HALT reached.
- fault  output  1  fetch timeout.

Behaviour:
- Control word layout, MSB to LSB:
  - [32] alu enable, [31] alu_b select, [30:26] alu fs
  - [25] rf_b enable, [24:20] SA, [19:15] SB, [14:10] DA, [9] rf write
  - [8] ram enable, [7] ram write
  - [6] pc enable, [5:4] pc fs, [3] pc input select
  - [2] status load, [1:0] next_state
- Phases: FETCH, EXECUTE, HALT, FAULT.
- Reset: phase=FETCH, instruction=0, state=00, status=0, timeout counter=0. controlword, mem_request, halted and fault all take their FETCH values, listed below.
- FETCH outputs:
  - mem_request=1.
  - controlword=FETCH_WORD: pc enable=1, ram enable=1, pc fs=00 (hold), all other bits 0.
  - Counter increments each cycle mem_ready=0.
- FETCH, mem_ready=1:
  - instruction<=instr_in, state<=00, counter<=0, phase<=EXECUTE.
  - Same cycle, controlword pc fs=01 (PC+4).
  - mem_request deasserts the next cycle.
- FETCH, counter reaches FETCH_TIMEOUT with mem_ready=0: phase<=FAULT.
  - mem_ready in that same cycle wins; fetch completes.
- EXECUTE:
  - controlword=decoder_controlword, combinational passthrough.
  - status<=status_in at cycle end when controlword[2]=1.
  - next_state=00: phase<=FETCH, state<=00.
  - next_state!=00: state<=next_state, stay in EXECUTE. Micro-state loops are the decoder's responsibility.
- Instruction latched equal to 32'h00000000 (UDF): phase<=HALT in place of EXECUTE. HALT is entered the cycle after the fetch.
- HALT: controlword=0, mem_request=0, halted=1. Exit by reset only.
- FAULT: controlword=0, mem_request=0, fault=1. Exit by reset only.
- Reset mid-fetch or mid-execute: immediate asynchronous return to reset values. No partial instruction latch.
- mem_ready outside FETCH is ignored.

Optional Feature:
- Macro: CONTROL_SEQUENCER_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - Adds phase STEP_WAIT, entered instead of FETCH when EXECUTE completes (and after reset).
  - STEP_WAIT holds mem_request=0 and controlword=0 until step=1, then moves to FETCH.
  - The timeout counter does not run in STEP_WAIT.
- Undefined: no step port; behaviour exactly as above.

Decomposition:
- Shared package control_pkg:
  - phase enum (FETCH, EXECUTE, HALT, FAULT, STEP_WAIT).
  - Control-word bit-index constants.
  - FETCH_WORD constant.
  - PC fs encodings: HOLD=00, INC=01, BRANCH=11.
  - UDF_ENCODING constant.
- Natural sub-module: fetch_timeout_counter (clear/enable/expired).

Test Plan:
- Reset, mem_ready after 2 cycles, instr_in=32'hB4000041:
  - mem_request=1 for 3 cycles; controlword pc fs=01 on the ready cycle.
  - instruction=B4000041 and state=00 the next cycle.
- EXECUTE with decoder_controlword next_state sequence 01, 10, 00:
  - state shows 00, 01, 10 across 3 cycles, then FETCH with mem_request=1.
- controlword[2]=1, status_in=5'b10101 in EXECUTE: status=10101 the next cycle.
- Same case with controlword[2]=0: status unchanged.
- mem_ready held 0 for 15 cycles: fault=1, controlword=0, held until reset.
- Ready on the 15th cycle instead: normal fetch, no fault.
- instr_in=0 fetched: halted=1 the next cycle; mem_request stays 0 for 20 cycles.
- reset pulsed mid-EXECUTE at state=10: outputs return to reset values asynchronously; fetch restarts.
